spi_sram_slave: RTL and testbench

- Synthesizable 23LC-style serial SRAM slave that sits directly downstream of the CPU SoC's SPI pins (cs_n, mosi, miso).
- Used as the on-chip and FPGA memory target for the SPI SRAM master, and as the reference memory in system benches.
- The SPI clock is the system clock. The master drives mosi and samples miso synchronously to clk; this block does the same on the rising edge.

---
 rtl/spi_sram_pkg.sv | 35 +++
 rtl/spi_sram_slave_mem.sv | 29 ++
 rtl/spi_sram_slave.sv | 182 ++++++++++++++++++
 tb/tb_spi_sram_slave.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_sram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_sram_pkg
// Purpose  : Shared command codes, mode encodings and slave FSM states for
//            the SPI SRAM slave and master.
// Revision : 1.0 - initial release
// ============================================================================
package spi_sram_pkg;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_RDMR  = 8'h05;
    localparam logic [7:0] CMD_WRMR  = 8'h01;

    localparam logic [1:0] MODE_BYTE = 2'b00;
    localparam logic [1:0] MODE_SEQ  = 2'b01;
    localparam logic [1:0] MODE_PAGE = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_RDATA  = 3'd3,
        ST_WDATA  = 3'd4,
        ST_RDMR   = 3'd5,
        ST_WRMR   = 3'd6,
        ST_IGNORE = 3'd7
    } spi_slv_state_t;

    function automatic logic is_byte_mode(input logic [7:0] m);
        return m[7:6] == MODE_BYTE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sram_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : spi_sram_slave_mem
// Purpose  : 2^AW x 8 storage, synchronous write and asynchronous read.
// Revision : 1.0 - initial release
// ============================================================================
module spi_sram_slave_mem #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/spi_sram_slave.sv
`default_nettype none
// ============================================================================
// Module   : spi_sram_slave
// Purpose  : 23LC-style serial SRAM slave clocked directly by the system clk.
// Revision : 1.0 - initial release
// ============================================================================
module spi_sram_slave
    import spi_sram_pkg::*;
#(
    parameter int         AW        = 10,
    parameter int         PAGE_LOG2 = 5,
    parameter logic [7:0] MODE_RST  = 8'h40
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic [7:0] mode
);

    localparam logic [AW-1:0] c_page_mask = AW'((32'd1 << PAGE_LOG2) - 32'd1);

    spi_slv_state_t r_state, w_state_nxt;
    logic [4:0]     r_cnt, w_cnt_nxt;
    logic [2:0]     r_bit, w_bit_nxt;
    logic [6:0]     r_shift, w_shift_nxt;
    logic [AW-1:0]  r_addr, w_addr_nxt;
    logic           r_wr, w_wr_nxt;
    logic [7:0]     r_mode, w_mode_nxt;
    logic           r_miso, w_miso_nxt;

    logic           w_we;
    logic [7:0]     w_byte;
    logic [7:0]     w_rdata;
    logic [AW-1:0]  w_raddr;
    logic [AW-1:0]  w_addr_inc;
    logic [AW-1:0]  w_addr_adv;

    assign w_byte     = {r_shift, mosi};
    assign w_addr_inc = r_addr + AW'(1);
    assign w_addr_adv = (r_mode[7:6] == MODE_PAGE)
                      ? ((r_addr & ~c_page_mask) | (w_addr_inc & c_page_mask))
                      : w_addr_inc;
    // The final address bit arrives on the same edge as the first read bit.
    assign w_raddr    = (r_state == ST_ADDR) ? {r_addr[AW-2:0], mosi} : r_addr;

    spi_sram_slave_mem #(
        .AW (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_addr),
        .i_wdata (w_byte),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_addr  <= '0;
            r_wr    <= 1'b0;
            r_mode  <= MODE_RST;
            r_miso  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_addr  <= w_addr_nxt;
            r_wr    <= w_wr_nxt;
            r_mode  <= w_mode_nxt;
            r_miso  <= w_miso_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = {r_shift[5:0], mosi};
        w_addr_nxt  = r_addr;
        w_wr_nxt    = r_wr;
        w_mode_nxt  = r_mode;
        w_miso_nxt  = 1'b0;
        w_we        = 1'b0;

        if (cs_n) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            unique case (r_state)
                ST_IDLE, ST_CMD: begin
                    w_state_nxt = ST_CMD;
                    w_cnt_nxt   = r_cnt + 5'd1;
                    if (r_cnt == 5'd7) begin
                        w_bit_nxt = 3'd7;
                        case (w_byte)
                            CMD_READ: begin
                                w_state_nxt = ST_ADDR;
                                w_wr_nxt    = 1'b0;
                            end
                            CMD_WRITE: begin
                                w_state_nxt = ST_ADDR;
                                w_wr_nxt    = 1'b1;
                            end
                            CMD_RDMR: begin
                                w_state_nxt = ST_RDMR;
                                w_miso_nxt  = r_mode[7];
                                w_bit_nxt   = 3'd6;
                            end
                            CMD_WRMR: w_state_nxt = ST_WRMR;
                            default:  w_state_nxt = ST_IGNORE;
                        endcase
                    end
                end
                ST_ADDR: begin
                    w_cnt_nxt  = r_cnt + 5'd1;
                    w_addr_nxt = {r_addr[AW-2:0], mosi};
                    if (r_cnt == 5'd31) begin
                        if (r_wr) begin
                            w_state_nxt = ST_WDATA;
                            w_bit_nxt   = 3'd7;
                        end else begin
                            w_state_nxt = ST_RDATA;
                            w_miso_nxt  = w_rdata[7];
                            w_bit_nxt   = 3'd6;
                        end
                    end
                end
                ST_RDATA: begin
                    w_miso_nxt = w_rdata[r_bit];
                    w_bit_nxt  = r_bit - 3'd1;
                    if (r_bit == 3'd0) begin
                        if (is_byte_mode(r_mode)) begin
                            w_state_nxt = ST_IGNORE;
                        end else begin
                            w_addr_nxt = w_addr_adv;
                        end
                    end
                end
                ST_WDATA: begin
                    w_bit_nxt = r_bit - 3'd1;
                    if (r_bit == 3'd0) begin
                        w_we = 1'b1;
                        if (is_byte_mode(r_mode)) begin
                            w_state_nxt = ST_IGNORE;
                        end else begin
                            w_addr_nxt = w_addr_adv;
                        end
                    end
                end
                ST_RDMR: begin
                    w_miso_nxt = r_mode[r_bit];
                    w_bit_nxt  = r_bit - 3'd1;
                end
                ST_WRMR: begin
                    w_bit_nxt = r_bit - 3'd1;
                    if (r_bit == 3'd0) begin
                        w_mode_nxt  = w_byte;
                        w_state_nxt = ST_IGNORE;
                    end
                end
                ST_IGNORE: begin
                    w_state_nxt = ST_IGNORE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign miso = r_miso;
    assign mode = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_spi_sram_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_sram_slave
// Purpose  : Randomized scoreboard bench for spi_sram_slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_sram_slave;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic       clk    = 1'b0;
    logic       arst_n = 1'b0;
    logic       cs_n   = 1'b1;
    logic       mosi   = 1'b0;
    logic       miso;
    logic [7:0] mode;

    spi_sram_slave #(
        .AW        (AW),
        .PAGE_LOG2 (5),
        .MODE_RST  (8'h40)
    ) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .cs_n   (cs_n),
        .mosi   (mosi),
        .miso   (miso),
        .mode   (mode)
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] m_mem [DEPTH];
    logic [7:0] m_mode;
    logic [7:0] exp_q [$];
    logic [7:0] wbuf [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference address step: sequential wraps over the array, page wraps in 32 bytes.
    function automatic int adv(input int a);
        if (m_mode[7:6] == 2'b10) return (a / 32) * 32 + ((a % 32) + 1) % 32;
        return (a + 1) % DEPTH;
    endfunction

    task automatic send_bit(input logic b);
        @(negedge clk);
        cs_n = 1'b0;
        mosi = b;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic send_addr(input logic [23:0] a);
        for (int i = 23; i >= 0; i--) send_bit(a[i]);
    endtask

    task automatic send_junk(input int nbits);
        for (int i = 0; i < nbits; i++) send_bit(1'($urandom));
    endtask

    task automatic end_frame();
        @(negedge clk);
        cs_n = 1'b1;
        mosi = 1'b0;
    endtask

    task automatic do_write(input logic [23:0] a);
        int p;
        p = int'(a) % DEPTH;
        send_byte(8'h02);
        send_addr(a);
        foreach (wbuf[j]) begin
            send_byte(wbuf[j]);
            if (m_mode[7:6] == 2'b00) begin
                if (j == 0) m_mem[p] = wbuf[j];
            end else begin
                m_mem[p] = wbuf[j];
                p = adv(p);
            end
        end
        end_frame();
    endtask

    task automatic do_read(input logic [23:0] a, input int n);
        int p;
        p = int'(a) % DEPTH;
        for (int j = 0; j < n; j++) begin
            if (m_mode[7:6] == 2'b00) begin
                exp_q.push_back((j == 0) ? m_mem[p] : 8'h00);
            end else begin
                exp_q.push_back(m_mem[p]);
                p = adv(p);
            end
        end
        send_byte(8'h03);
        send_addr(a);
        send_junk(8 * n);
        end_frame();
    endtask

    task automatic do_wrmr(input logic [7:0] d);
        send_byte(8'h01);
        send_byte(d);
        end_frame();
        m_mode = d;
        chk("mode_reg", mode, m_mode);
    endtask

    task automatic do_rdmr(input int n);
        for (int j = 0; j < n; j++) exp_q.push_back(m_mode);
        send_byte(8'h05);
        send_junk(8 * n);
        end_frame();
    endtask

    // Monitor: reassembles each frame from the pins and checks it against the queue.
    logic       mon_bits [$];
    int         mon_n   = 0;
    logic [7:0] mon_cmd = 8'h00;
    bit         mon_in  = 1'b0;

    task automatic check_frame();
        int         start;
        int         nz;
        int         nb;
        logic [7:0] b;
        start = -1;
        nz    = 0;
        if (mon_cmd == 8'h03 && mon_n >= 32) start = 31;
        else if (mon_cmd == 8'h05 && mon_n >= 8) start = 7;
        for (int i = 0; i < mon_n; i++) begin
            if ((start < 0 || i < start) && mon_bits[i] !== 1'b0) nz++;
        end
        chk("miso_quiet", nz, 0);
        if (start >= 0) begin
            nb = (mon_n - start) / 8;
            for (int j = 0; j < nb; j++) begin
                b = 8'h00;
                for (int k = 0; k < 8; k++) b = {b[6:0], mon_bits[start + 8 * j + k]};
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_underflow: got byte %0h with nothing expected", b);
                end else begin
                    chk("rd_byte", b, exp_q.pop_front());
                end
            end
        end
    endtask

    always @(posedge clk) begin
        logic c, m, r;
        c = cs_n;
        m = mosi;
        r = arst_n;
        #1;
        if (!r) begin
            mon_in = 1'b0;
            mon_n  = 0;
            mon_bits.delete();
        end else if (!c) begin
            if (!mon_in) begin
                mon_in  = 1'b1;
                mon_n   = 0;
                mon_cmd = 8'h00;
                mon_bits.delete();
            end
            if (mon_n < 8) mon_cmd = {mon_cmd[6:0], m};
            mon_bits.push_back(miso);
            mon_n++;
        end else if (mon_in) begin
            mon_in = 1'b0;
            chk("miso_after_cs", miso, 0);
            check_frame();
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int         op;
        int         n;
        logic [23:0] a;
        logic [7:0]  d;

        m_mode = 8'h40;
        repeat (3) @(negedge clk);
        chk("reset_miso", miso, 0);
        chk("reset_mode", mode, 8'h40);
        arst_n = 1'b1;
        @(negedge clk);

        // Known contents everywhere so every later read has a defined expectation.
        wbuf.delete();
        for (int i = 0; i < DEPTH; i++) wbuf.push_back(8'($urandom));
        do_write(24'h000000);

        wbuf = '{8'hA5, 8'h5A};
        do_write(24'h000100);
        do_read(24'h000100, 2);

        wbuf = '{8'h11, 8'h22};
        do_write(24'h0003FF);
        do_read(24'h000000, 1);
        do_read(24'hFFFC00, 1);

        do_wrmr(8'h80);
        do_rdmr(2);
        wbuf = '{8'hC3, 8'h3C};
        do_write(24'h00001F);
        do_read(24'h000000, 1);

        do_wrmr(8'h00);
        wbuf = '{8'h77, 8'h88};
        do_write(24'h000010);
        do_read(24'h000010, 2);
        do_read(24'h000011, 1);

        do_wrmr(8'h40);
        send_byte(8'h02);
        send_addr(24'h000020);
        send_junk(5);
        end_frame();
        do_read(24'h000020, 1);

        send_byte(8'h9F);
        send_junk(16);
        end_frame();
        chk("unknown_mode", mode, m_mode);
        do_read(24'h000100, 2);

        do_wrmr(8'hC0);
        wbuf = '{8'hDE, 8'hAD, 8'hBE};
        do_write(24'h0003FE);
        do_read(24'h0003FE, 3);
        send_byte(8'h01);
        send_junk(4);
        end_frame();
        chk("wrmr_trunc", mode, m_mode);
        do_rdmr(1);

        for (int it = 0; it < 30; it++) begin
            op = $urandom_range(0, 3);
            a  = 24'($urandom);
            n  = $urandom_range(1, 4);
            d  = 8'($urandom);
            case (op)
                0: begin
                    wbuf.delete();
                    for (int j = 0; j < n; j++) wbuf.push_back(8'($urandom));
                    do_write(a);
                end
                1: do_read(a, n);
                2: do_wrmr(d);
                default: do_rdmr(n);
            endcase
        end

        do_wrmr(8'h80);
        wbuf = '{8'hFF, 8'hFF};
        do_write(24'h000200);
        send_byte(8'h03);
        send_addr(24'h000200);
        send_junk(10);
        @(negedge clk);
        #1;
        arst_n = 1'b0;
        cs_n   = 1'b1;
        #1;
        chk("rstmid_miso", miso, 0);
        chk("rstmid_mode", mode, 8'h40);
        m_mode = 8'h40;
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        do_read(24'h000200, 2);
        do_rdmr(1);

        repeat (4) @(negedge clk);
        chk("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
